// File: rtl/ethernet_mmio_arbiter.sv
// Two-requester round-robin arbiter in front of the Ethernet MMIO decoder.
// Grants are combinational, every transfer gets a 1-cycle response routed back
// to its issuer, and a per-requester lock holds the port for bounded sequences.
module ethernet_mmio_arbiter #(
    parameter int unsigned data_width_p      = 32,
    parameter int unsigned addr_width_p      = 16,
    parameter int unsigned lock_max_p        = 64,
    parameter int unsigned lock_cnt_width_lp = $clog2(lock_max_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [1:0]                req_v_i,
    output logic [1:0]                req_ready_o,
    input  logic [1:0]                req_we_i,
    input  logic [1:0]                req_lock_i,
    input  logic [2*addr_width_p-1:0] req_addr_i,
    input  logic [3:0]                req_op_size_i,
    input  logic [2*data_width_p-1:0] req_wdata_i,
    output logic [1:0]                resp_v_o,
    output logic                      resp_err_o,
    output logic [data_width_p-1:0]   resp_data_o,
    output logic                      lock_broken_o,
    input  logic                      lock_broken_clr_i,
    output logic [addr_width_p-1:0]   mmio_addr_o,
    output logic                      mmio_read_en_o,
    output logic                      mmio_write_en_o,
    output logic [1:0]                mmio_op_size_o,
    output logic [data_width_p-1:0]   mmio_write_data_o,
    input  logic [data_width_p-1:0]   mmio_read_data_i,
    input  logic                      mmio_decode_error_i
);

    typedef enum logic {StUnlocked, StLocked} lock_state_e;

    // Last counter value before the hold limit is hit (counter + 1 reaches lock_max_p).
    localparam logic [lock_cnt_width_lp-1:0] lock_last_lp = lock_cnt_width_lp'(lock_max_p - 1);

    lock_state_e                  state_q, state_d;
    logic                         owner_q, owner_d;
    logic [lock_cnt_width_lp-1:0] cnt_q, cnt_d;
    logic                         rr_q, rr_d;
    logic                         broken_q, broken_d;
    logic                         resp_pend_q, resp_pend_d;
    logic                         resp_owner_q, resp_owner_d;
    logic                         resp_read_q, resp_read_d;
    logic                         resp_err_q, resp_err_d;

    logic [1:0] grant;
    logic       gnt_any;
    logic       gnt_idx;
    logic       we_sel;
    logic       lock_sel;
    logic       brk_set;

    // Grant selection; held off while reset is asserted so nothing reaches the decoder.
    always_comb begin
        grant = 2'b00;
        if (reset_n_i) begin
            if (state_q == StLocked) begin
                grant[owner_q] = req_v_i[owner_q];
            end else if (req_v_i == 2'b11) begin
                grant[rr_q] = 1'b1;
            end else begin
                grant = req_v_i;
            end
        end
    end

    assign gnt_any     = |grant;
    assign gnt_idx     = grant[1];
    assign we_sel      = req_we_i[gnt_idx];
    assign lock_sel    = req_lock_i[gnt_idx];
    assign req_ready_o = grant;

    // Winner's request muxed onto the decoder port, all zero when idle.
    always_comb begin
        mmio_addr_o       = '0;
        mmio_op_size_o    = 2'b00;
        mmio_write_data_o = '0;
        mmio_read_en_o    = 1'b0;
        mmio_write_en_o   = 1'b0;
        if (gnt_any) begin
            mmio_addr_o       = gnt_idx ? req_addr_i[2*addr_width_p-1:addr_width_p]
                                        : req_addr_i[addr_width_p-1:0];
            mmio_op_size_o    = gnt_idx ? req_op_size_i[3:2] : req_op_size_i[1:0];
            mmio_write_data_o = gnt_idx ? req_wdata_i[2*data_width_p-1:data_width_p]
                                        : req_wdata_i[data_width_p-1:0];
            mmio_read_en_o    = ~we_sel;
            mmio_write_en_o   = we_sel;
        end
    end

    // Lock state, hold counter, round-robin pointer and sticky break flag.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        brk_set = 1'b0;
        unique case (state_q)
            StUnlocked: begin
                if (gnt_any && (req_v_i == 2'b11)) begin
                    rr_d = ~gnt_idx;
                end
                if (gnt_any && lock_sel) begin
                    state_d = StLocked;
                    owner_d = gnt_idx;
                    cnt_d   = lock_cnt_width_lp'(1);
                end
            end
            StLocked: begin
                if ((gnt_any && !lock_sel) ||
                    (!req_v_i[owner_q] && !req_lock_i[owner_q])) begin
                    // Voluntary release takes priority over the hold limit.
                    state_d = StUnlocked;
                    cnt_d   = '0;
                end else if (cnt_q >= lock_last_lp) begin
                    state_d = StUnlocked;
                    cnt_d   = '0;
                    rr_d    = ~owner_q;
                    brk_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StUnlocked;
            end
        endcase
        // A break in the same cycle as a clear leaves the flag set.
        broken_d = brk_set | (broken_q & ~lock_broken_clr_i);
    end

    // Capture who owns the response due next cycle.
    always_comb begin
        resp_pend_d  = gnt_any;
        resp_owner_d = gnt_idx;
        resp_read_d  = gnt_any & ~we_sel;
        resp_err_d   = gnt_any & mmio_decode_error_i;
    end

    // Response presentation; read data is passed through only for clean reads.
    always_comb begin
        resp_v_o = 2'b00;
        if (resp_pend_q) begin
            resp_v_o[resp_owner_q] = 1'b1;
        end
        resp_err_o    = resp_pend_q & resp_err_q;
        resp_data_o   = (resp_pend_q && resp_read_q && !resp_err_q) ? mmio_read_data_i : '0;
        lock_broken_o = broken_q;
    end

    // State registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= StUnlocked;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            rr_q         <= 1'b0;
            broken_q     <= 1'b0;
            resp_pend_q  <= 1'b0;
            resp_owner_q <= 1'b0;
            resp_read_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            rr_q         <= rr_d;
            broken_q     <= broken_d;
            resp_pend_q  <= resp_pend_d;
            resp_owner_q <= resp_owner_d;
            resp_read_q  <= resp_read_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_ethernet_mmio_arbiter.sv
// Bench for ethernet_mmio_arbiter: directed vector table, lock/reset sequences,
// and random traffic against a transaction-level model (two lock limits).
module tb_ethernet_mmio_arbiter;

    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    req_v, req_we, req_lock;
    logic [2*AW-1:0] req_addr;
    logic [3:0]    req_size;
    logic [2*DW-1:0] req_wdata;
    logic          clr;
    logic [DW-1:0] rdata;
    logic          derr;

    logic [1:0]    rdy_a, rv_a, rdy_b, rv_b;
    logic          rerr_a, brk_a, rd_a, wr_a, rerr_b, brk_b, rd_b, wr_b;
    logic [DW-1:0] rdat_a, wdat_a, rdat_b, wdat_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [1:0]    size_a, size_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ethernet_mmio_arbiter dut_a (
        .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_ready_o(rdy_a),
        .req_we_i(req_we), .req_lock_i(req_lock), .req_addr_i(req_addr),
        .req_op_size_i(req_size), .req_wdata_i(req_wdata), .resp_v_o(rv_a),
        .resp_err_o(rerr_a), .resp_data_o(rdat_a), .lock_broken_o(brk_a),
        .lock_broken_clr_i(clr), .mmio_addr_o(addr_a), .mmio_read_en_o(rd_a),
        .mmio_write_en_o(wr_a), .mmio_op_size_o(size_a), .mmio_write_data_o(wdat_a),
        .mmio_read_data_i(rdata), .mmio_decode_error_i(derr)
    );

    ethernet_mmio_arbiter #(.lock_max_p(4)) dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_ready_o(rdy_b),
        .req_we_i(req_we), .req_lock_i(req_lock), .req_addr_i(req_addr),
        .req_op_size_i(req_size), .req_wdata_i(req_wdata), .resp_v_o(rv_b),
        .resp_err_o(rerr_b), .resp_data_o(rdat_b), .lock_broken_o(brk_b),
        .lock_broken_clr_i(clr), .mmio_addr_o(addr_b), .mmio_read_en_o(rd_b),
        .mmio_write_en_o(wr_b), .mmio_op_size_o(size_b), .mmio_write_data_o(wdat_b),
        .mmio_read_data_i(rdata), .mmio_decode_error_i(derr)
    );

    typedef struct {
        logic [1:0]  v, we;
        logic [15:0] a0, a1;
        logic [31:0] w0, w1, rd;
        logic        derr;
        logic [1:0]  e_rdy;
        logic        e_rd, e_wr;
        logic [15:0] e_addr;
        logic [31:0] e_wdata;
        logic [1:0]  e_size, e_rv;
        logic        e_err;
        logic [31:0] e_data;
    } vec_t;

    typedef struct {
        bit          locked;
        bit          owner;
        int unsigned held;
        bit          rr;
        bit          broken;
        bit          pend;
        bit          p_owner;
        bit          p_read;
        bit          p_err;
        int unsigned max;
    } model_t;

    vec_t vecs[11];

    function automatic logic [127:0] pack_a();
        return {39'b0, rdy_a, rd_a, wr_a, addr_a, wdat_a, size_a, rv_a, rerr_a, rdat_a};
    endfunction

    function automatic logic [127:0] pack_b();
        return {39'b0, rdy_b, rd_b, wr_b, addr_b, wdat_b, size_b, rv_b, rerr_b, rdat_b};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                          input logic [15:0] a0, input logic [15:0] a1,
                          input logic [31:0] w0, input logic [31:0] w1);
        req_v     = v;
        req_we    = we;
        req_lock  = lk;
        req_addr  = {a1, a0};
        req_wdata = {w1, w0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clr     = 1'b0;
        derr    = 1'b0;
        rdata   = '0;
        set_in(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Which requester the specification's rules pick this cycle (-1 = nobody).
    function automatic int m_winner(input model_t m);
        if (m.locked) return req_v[m.owner] ? int'(m.owner) : -1;
        if (req_v == 2'b11) return int'(m.rr);
        if (req_v[0]) return 0;
        if (req_v[1]) return 1;
        return -1;
    endfunction

    function automatic logic [127:0] m_expect(input model_t m, input int w);
        logic [1:0]  rdy = 2'b00;
        logic        rd = 1'b0, wr = 1'b0;
        logic [15:0] ad = '0;
        logic [31:0] wd = '0;
        logic [1:0]  sz = 2'b00;
        logic [1:0]  rv = 2'b00;
        logic        er;
        logic [31:0] da;
        if (w >= 0) begin
            rdy[w] = 1'b1;
            rd     = !req_we[w];
            wr     = req_we[w];
            ad     = req_addr[w*AW +: AW];
            wd     = req_wdata[w*DW +: DW];
            sz     = req_size[w*2 +: 2];
        end
        if (m.pend) rv[m.p_owner] = 1'b1;
        er = m.pend && m.p_err;
        da = (m.pend && m.p_read && !m.p_err) ? rdata : 32'h0;
        return {39'b0, rdy, rd, wr, ad, wd, sz, rv, er, da};
    endfunction

    function automatic model_t m_step(input model_t m, input int w);
        model_t n = m;
        bit     brk = 1'b0;
        n.pend    = (w >= 0);
        n.p_owner = (w == 1);
        n.p_read  = (w >= 0) && !req_we[w];
        n.p_err   = (w >= 0) && derr;
        if (!m.locked) begin
            if (w >= 0 && req_v == 2'b11) n.rr = (w == 0);
            if (w >= 0 && req_lock[w]) begin
                n.locked = 1'b1;
                n.owner  = (w == 1);
                n.held   = 1;
            end
        end else if ((w >= 0 && !req_lock[m.owner]) ||
                     (!req_v[m.owner] && !req_lock[m.owner])) begin
            n.locked = 1'b0;
        end else begin
            n.held = m.held + 1;
            if (n.held >= m.max) begin
                n.locked = 1'b0;
                n.rr     = !m.owner;
                brk      = 1'b1;
            end
        end
        n.broken = brk ? 1'b1 : (clr ? 1'b0 : m.broken);
        return n;
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_t ma, mb;
        int     wa, wb;

        // {v, we, a0, a1, w0, w1, rdata, derr | rdy, rd, wr, addr, wdata, size, resp_v, err, data}
        vecs[0]  = '{2'b01, 2'b00, 16'h101C, 16'h0, 32'h0, 32'h0, 32'h0, 1'b0,
                     2'b01, 1'b1, 1'b0, 16'h101C, 32'h0, 2'b10, 2'b00, 1'b0, 32'h0};
        vecs[1]  = '{2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0, 32'h1, 1'b0,
                     2'b00, 1'b0, 1'b0, 16'h0, 32'h0, 2'b00, 2'b01, 1'b0, 32'h1};
        vecs[2]  = '{2'b11, 2'b00, 16'h1000, 16'h2000, 32'h0A0A, 32'h0B0B, 32'h0, 1'b0,
                     2'b01, 1'b1, 1'b0, 16'h1000, 32'h0A0A, 2'b10, 2'b00, 1'b0, 32'h0};
        vecs[3]  = '{2'b11, 2'b00, 16'h1004, 16'h2004, 32'h0A0A, 32'h0B0B, 32'hAAAA, 1'b0,
                     2'b10, 1'b1, 1'b0, 16'h2004, 32'h0B0B, 2'b01, 2'b01, 1'b0, 32'hAAAA};
        vecs[4]  = '{2'b11, 2'b00, 16'h1008, 16'h2008, 32'h0A0A, 32'h0B0B, 32'hBBBB, 1'b0,
                     2'b01, 1'b1, 1'b0, 16'h1008, 32'h0A0A, 2'b10, 2'b10, 1'b0, 32'hBBBB};
        vecs[5]  = '{2'b11, 2'b00, 16'h100C, 16'h200C, 32'h0A0A, 32'h0B0B, 32'hCCCC, 1'b0,
                     2'b10, 1'b1, 1'b0, 16'h200C, 32'h0B0B, 2'b01, 2'b01, 1'b0, 32'hCCCC};
        vecs[6]  = '{2'b01, 2'b01, 16'h0100, 16'h0, 32'h55, 32'h0, 32'hDDDD, 1'b1,
                     2'b01, 1'b0, 1'b1, 16'h0100, 32'h55, 2'b10, 2'b10, 1'b0, 32'hDDDD};
        vecs[7]  = '{2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0, 32'h1234, 1'b0,
                     2'b00, 1'b0, 1'b0, 16'h0, 32'h0, 2'b00, 2'b01, 1'b1, 32'h0};
        vecs[8]  = '{2'b10, 2'b10, 16'h0, 16'h3000, 32'h0, 32'h77, 32'h0, 1'b0,
                     2'b10, 1'b0, 1'b1, 16'h3000, 32'h77, 2'b01, 2'b00, 1'b0, 32'h0};
        vecs[9]  = '{2'b11, 2'b00, 16'h1010, 16'h2010, 32'h0A0A, 32'h0B0B, 32'h9999, 1'b0,
                     2'b01, 1'b1, 1'b0, 16'h1010, 32'h0A0A, 2'b10, 2'b10, 1'b0, 32'h0};
        vecs[10] = '{2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0, 32'h4321, 1'b0,
                     2'b00, 1'b0, 1'b0, 16'h0, 32'h0, 2'b00, 2'b01, 1'b0, 32'h4321};

        req_size = 4'b0110;  // req 1 size 01, req 0 size 10
        reset_n  = 1'b0;
        clr      = 1'b0;
        derr     = 1'b1;
        rdata    = 32'hFFFF_FFFF;
        set_in(2'b11, 2'b01, 2'b11, 16'h1111, 16'h2222, 32'h3, 32'h4);
        @(negedge clk);
        check("reset_outputs_a", {pack_a(), brk_a}, '0);
        check("reset_outputs_b", {pack_b(), brk_b}, '0);
        do_reset();

        // Directed vectors.
        for (int i = 0; i < 11; i++) begin
            set_in(vecs[i].v, vecs[i].we, 2'b00, vecs[i].a0, vecs[i].a1, vecs[i].w0, vecs[i].w1);
            rdata = vecs[i].rd;
            derr  = vecs[i].derr;
            @(negedge clk);
            check($sformatf("vec%0d", i), pack_a(),
                  {39'b0, vecs[i].e_rdy, vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_addr,
                   vecs[i].e_wdata, vecs[i].e_size, vecs[i].e_rv, vecs[i].e_err, vecs[i].e_data});
            tick();
        end

        // Locked write pair from req 1; req 0 must wait until the unlocking write.
        do_reset();
        set_in(2'b10, 2'b10, 2'b10, 16'h0, 16'h1028, 32'h0, 32'h40);
        @(negedge clk);
        check("lock_acquire", {rdy_a, wr_a, addr_a, wdat_a}, {2'b10, 1'b1, 16'h1028, 32'h40});
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(2'b01, 2'b00, 2'b10, 16'h2000, 16'h0, 32'h0, 32'h0);
            @(negedge clk);
            check($sformatf("lock_hold%0d", i), {rdy_a, rd_a}, {2'b00, 1'b0});
            tick();
        end
        set_in(2'b11, 2'b10, 2'b00, 16'h2000, 16'h1018, 32'h0, 32'h1);
        @(negedge clk);
        check("lock_release", {rdy_a, wr_a, addr_a, wdat_a}, {2'b10, 1'b1, 16'h1018, 32'h1});
        tick();
        set_in(2'b01, 2'b00, 2'b00, 16'h2000, 16'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("after_unlock", rdy_a, 2'b01);
        tick();

        // Forced break on the 4-cycle instance.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(2'b11, 2'b00, 2'b01, 16'h1000, 16'h2000, 32'h0, 32'h0);
            @(negedge clk);
            check($sformatf("brk_hold%0d", i), {rdy_b, brk_b}, {2'b01, 1'b0});
            tick();
        end
        set_in(2'b11, 2'b00, 2'b00, 16'h1000, 16'h2000, 32'h0, 32'h0);
        @(negedge clk);
        check("brk_flag_grant", {rdy_b, brk_b}, {2'b10, 1'b1});
        tick();
        set_in(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0);
        clr = 1'b1;
        @(negedge clk);
        check("brk_before_clr", brk_b, 1'b1);
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("brk_cleared", brk_b, 1'b0);
        tick();

        // Reset right after a locked read issue.
        do_reset();
        tick();
        tick();  // move rr nowhere; just idle cycles
        set_in(2'b01, 2'b00, 2'b01, 16'h1010, 16'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("locked_read_issue", {rdy_a, rd_a}, {2'b01, 1'b1});
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        set_in(2'b11, 2'b00, 2'b01, 16'h1010, 16'h2020, 32'h0, 32'h0);
        rdata = 32'h5A5A;
        @(negedge clk);
        check("reset_mid_lock", {pack_a(), brk_a}, '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        set_in(2'b11, 2'b00, 2'b00, 16'h1010, 16'h2020, 32'h0, 32'h0);
        @(negedge clk);
        check("post_reset_grant", {rdy_a, rv_a}, {2'b01, 2'b00});
        tick();

        // Random traffic against the transaction-level model.
        do_reset();
        ma     = '{default: 0};
        mb     = '{default: 0};
        ma.max = 64;
        mb.max = 4;
        for (int c = 0; c < 3000; c++) begin
            req_v     = 2'($urandom);
            req_we    = 2'($urandom);
            req_lock  = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            req_addr  = $urandom;
            req_size  = 4'($urandom);
            req_wdata = {$urandom, $urandom};
            rdata     = $urandom;
            derr      = ($urandom_range(0, 3) == 0);
            clr       = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            wa = m_winner(ma);
            wb = m_winner(mb);
            check($sformatf("rand_a_c%0d", c), {pack_a(), brk_a}, {m_expect(ma, wa), ma.broken});
            check($sformatf("rand_b_c%0d", c), {pack_b(), brk_b}, {m_expect(mb, wb), mb.broken});
            @(posedge clk);
            ma = m_step(ma, wa);
            mb = m_step(mb, wb);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
